seq_divmod: RTL

Multi-cycle sequential unsigned divider that returns quotient and remainder together, using radix-2 restoring division. It is the iterative counterpart to the datapath MUL block and a low-area alternative to the combinational DIV/MOD pair. It is intended for datapaths that can tolerate latency and need a start/done handshake instead of a single-cycle path. Operands are captured on start, one quotient bit is resolved per clock, and results are held in output registers until the next completion.

---
 rtl/seq_divmod.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_divmod.sv
// -----------------------------------------------------------------------------
// seq_divmod
//   Multi-cycle unsigned divider (radix-2 restoring). Produces quotient and
//   remainder together, resolving one quotient bit per clock. Operands are
//   captured when start is accepted in IDLE. Results are held in output
//   registers until the next completion.
//
//   Optional feature macro: DIVZERO_DETECT_EN
//     When defined, a zero divisor short-circuits the iteration: results and
//     the divzero flag are produced on the accepting edge.
//
// Parameters
//   DATAWIDTH  operand/result width (2..64)
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous, active-high reset
//   start    request a division (accepted only in IDLE)
//   a, b     unsigned dividend / divisor, sampled on the accepting edge
//   quot     registered quotient  a / b
//   rem      registered remainder a % b
//   busy     high while RUN or DONE
//   divzero  (DIVZERO_DETECT_EN only) last accepted divisor was zero
//   done     one-cycle pulse, quot/rem valid in the same cycle
// -----------------------------------------------------------------------------
module seq_divmod #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 busy,
`ifdef DIVZERO_DETECT_EN
  output logic                 divzero,
`endif
  output logic                 done
);

  localparam int CW = $clog2(DATAWIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  // Dividend shift register. Quotient bits enter at the LSB as dividend bits
  // leave at the MSB, so after DATAWIDTH iterations it holds the quotient.
  logic [DATAWIDTH-1:0]   dvd;
  logic [DATAWIDTH-1:0]   dvs;
  // Partial remainder. The restored value is always below the divisor, so
  // only the working value t needs the extra bit.
  logic [DATAWIDTH-1:0]   p;

  logic [DATAWIDTH:0]     t;
  logic                   ge;
  logic [DATAWIDTH-1:0]   diff;
  logic [DATAWIDTH-1:0]   p_next;

  assign t      = {p, dvd[DATAWIDTH-1]};
  assign ge     = (t >= {1'b0, dvs});
  // When ge holds the true difference is below dvs, so the low bits suffice.
  assign diff   = t[DATAWIDTH-1:0] - dvs;
  assign p_next = ge ? diff : t[DATAWIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      p     <= '0;
      quot  <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef DIVZERO_DETECT_EN
      divzero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd  <= a;
            dvs  <= b;
            p    <= '0;
            cnt  <= CW'(DATAWIDTH);
            busy <= 1'b1;
            state <= RUN;
`ifdef DIVZERO_DETECT_EN
            divzero <= 1'b0;
            if (b == '0) begin
              quot    <= '1;
              rem     <= a;
              divzero <= 1'b1;
              done    <= 1'b1;
              state   <= DONE;
            end
`endif
          end
        end

        RUN: begin
          p   <= p_next;
          dvd <= {dvd[DATAWIDTH-2:0], ge};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quot  <= {dvd[DATAWIDTH-2:0], ge};
            rem   <= p_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          // start is deliberately ignored here; the next request is taken
          // one cycle later in IDLE.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
